// File: rtl/aes_enc_feeder.sv
// Plaintext FIFO, key-expansion sequencer and credit-gated issue for the AES-128 core.
// Optional sticky protocol-error flag when AES_FEED_ERR_EN is defined.
module aes_enc_feeder #(
   parameter int BLOCK_LENGTH   = 128,
   parameter int FIFO_DEPTH     = 4,
   parameter int KEY_EXP_CYCLES = 12,
   parameter int CREDITS        = 12
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [BLOCK_LENGTH-1:0] i_key_in,
   input  logic                    i_key_load,
   input  logic                    i_s_valid,
   output logic                    o_s_ready,
   input  logic [BLOCK_LENGTH-1:0] i_s_data,
   output logic [BLOCK_LENGTH-1:0] o_key_out,
   output logic                    o_fsm_en,
   output logic                    o_key_ready,
   output logic [BLOCK_LENGTH-1:0] o_pt_out,
   output logic                    o_pt_en,
   input  logic                    i_credit_ret,
   output logic [7:0]              o_inflight
`ifdef AES_FEED_ERR_EN
   ,
   output logic                    o_err
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(KEY_EXP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      KEXP,
      RUN,
      DRAIN
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [CW-1:0]           r_cnt;
   logic [BLOCK_LENGTH-1:0] r_key;
   logic [BLOCK_LENGTH-1:0] r_pend;
   logic [BLOCK_LENGTH-1:0] r_pt;
   logic                    r_pt_en;
   logic [7:0]              r_inflight;
   logic [BLOCK_LENGTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW:0]             r_wp;
   logic [PW:0]             r_rp;

   logic                    w_empty;
   logic                    w_full;
   logic                    w_s_ready;
   logic                    w_push;
   logic                    w_issue;
   logic                    w_cr;
   logic                    w_fsm_en;
   logic                    w_key_ready;
   logic                    w_key_we;
   logic [BLOCK_LENGTH-1:0] w_key_d;
   logic                    w_cnt_clr;

   assign w_empty   = (r_wp == r_rp);
   assign w_full    = (r_wp[PW] != r_rp[PW]) &&
                      (r_wp[PW-1:0] == r_rp[PW-1:0]);
   assign w_s_ready = !w_full && !i_rst;
   assign w_push    = i_s_valid && w_s_ready;
   assign w_issue   = (r_state == RUN) && !w_empty &&
                      (r_inflight < 8'(CREDITS));
   // A return with nothing in flight is dropped so the count never wraps.
   assign w_cr      = i_credit_ret && (r_inflight != 8'd0);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_fsm_en    = 1'b0;
      w_key_ready = 1'b0;
      w_key_we    = 1'b0;
      w_key_d     = i_key_in;
      w_cnt_clr   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_key_load) begin
               w_key_we  = 1'b1;
               w_cnt_clr = 1'b1;
               w_next    = KEXP;
            end
         end
         KEXP: begin
            w_fsm_en = 1'b1;
            if (i_key_load) begin
               w_key_we  = 1'b1;
               w_cnt_clr = 1'b1;
            end else if (r_cnt == CW'(KEY_EXP_CYCLES - 1)) begin
               w_next = RUN;
            end
         end
         RUN: begin
            w_key_ready = 1'b1;
            if (i_key_load) w_next = DRAIN;
         end
         DRAIN: begin
            if (r_inflight == 8'd0) begin
               w_key_we  = 1'b1;
               w_key_d   = i_key_load ? i_key_in : r_pend;
               w_cnt_clr = 1'b1;
               w_next    = KEXP;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_key  <= '0;
         r_pend <= '0;
      end else begin
         if (w_cnt_clr)             r_cnt <= '0;
         else if (r_state == KEXP)  r_cnt <= r_cnt + CW'(1);
         if (w_key_we)              r_key <= w_key_d;
         if (i_key_load && (r_state == RUN || r_state == DRAIN))
            r_pend <= i_key_in;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wp[PW-1:0]] <= i_s_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_pt       <= '0;
         r_pt_en    <= 1'b0;
         r_inflight <= 8'd0;
      end else begin
         if (w_push)  r_wp <= r_wp + 1'b1;
         if (w_issue) begin
            r_rp <= r_rp + 1'b1;
            r_pt <= r_mem[r_rp[PW-1:0]];
         end
         r_pt_en    <= w_issue;
         r_inflight <= r_inflight + {7'd0, w_issue} - {7'd0, w_cr};
      end
   end

`ifdef AES_FEED_ERR_EN
   logic                    r_err;
   logic                    r_stall_v;
   logic [BLOCK_LENGTH-1:0] r_stall_d;

   // A stalled beat must keep its data until it is accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err     <= 1'b0;
         r_stall_v <= 1'b0;
         r_stall_d <= '0;
      end else begin
         r_stall_v <= i_s_valid && !w_s_ready;
         r_stall_d <= i_s_data;
         if ((i_credit_ret && r_inflight == 8'd0) ||
             (r_stall_v && i_s_valid && i_s_data != r_stall_d))
            r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`endif

   assign o_s_ready   = w_s_ready;
   assign o_key_out   = r_key;
   assign o_fsm_en    = w_fsm_en;
   assign o_key_ready = w_key_ready;
   assign o_pt_out    = r_pt;
   assign o_pt_en     = r_pt_en;
   assign o_inflight  = r_inflight;

endmodule

// File: tb/tb_aes_enc_feeder.sv
// Directed bench for aes_enc_feeder: key sequencing, FIFO order, credits, reset.
// Issued blocks are checked against a queue of accepted plaintext beats.
module tb_aes_enc_feeder;

   logic         clk;
   logic         rst;
   logic [127:0] key_in;
   logic         key_load;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_data;
   logic [127:0] key_out;
   logic         fsm_en;
   logic         key_ready;
   logic [127:0] pt_out;
   logic         pt_en;
   logic         credit_ret;
   logic [7:0]   inflight;
`ifdef AES_FEED_ERR_EN
   logic         err;
`endif

   int checks = 0;
   int errors = 0;
   int issued = 0;
   int fsm_cnt = 0;
   int beat_n = 0;
   int iss0;
   logic [127:0] q[$];

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;

   aes_enc_feeder dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_key_in     (key_in),
      .i_key_load   (key_load),
      .i_s_valid    (s_valid),
      .o_s_ready    (s_ready),
      .i_s_data     (s_data),
      .o_key_out    (key_out),
      .o_fsm_en     (fsm_en),
      .o_key_ready  (key_ready),
      .o_pt_out     (pt_out),
      .o_pt_en      (pt_en),
      .i_credit_ret (credit_ret),
`ifdef AES_FEED_ERR_EN
      .o_err        (err),
`endif
      .o_inflight   (inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (fsm_en === 1'b1) fsm_cnt++;
      if (!rst && pt_en === 1'b1) begin
         issued++;
         if (q.size() == 0) chk("sb_unexpected", 128'd1, 128'd0);
         else chk("sb_data", pt_out, q.pop_front());
      end
   end

   task automatic send();
      int n;
      logic [127:0] d;
      n = 0;
      beat_n++;
      d = {4{32'(beat_n)}} ^ 128'h5a5a_0000_c3c3_0000_1234_0000_0f0f_0000;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) chk("send_timeout", 128'(s_ready), 128'd1);
      else q.push_back(d);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (key_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("key_ready_timeout", 128'(key_ready), 128'd1);
   endtask

   task automatic pulse_key(input logic [127:0] k);
      key_in   = k;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      key_in = '0;
      key_load = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      credit_ret = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 128'(s_ready), 128'd0);
      chk("rst_key_out", key_out, 128'd0);
      chk("rst_fsm_en", 128'(fsm_en), 128'd0);
      chk("rst_key_ready", 128'(key_ready), 128'd0);
      chk("rst_pt_en", 128'(pt_en), 128'd0);
      chk("rst_inflight", 128'(inflight), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_s_ready", 128'(s_ready), 128'd1);

      // key expansion with four beats buffered meanwhile
      fsm_cnt = 0;
      pulse_key(K1);
      repeat (4) send();
      chk("t2_full", 128'(s_ready), 128'd0);
      chk("t2_no_issue_kexp", 128'(issued), 128'd0);
      wait_ready();
      chk("t1_fsm_cycles", 128'(fsm_cnt), 128'd12);
      chk("t1_key_out", key_out, K1);
      chk("t2_first_run_pt_en", 128'(pt_en), 128'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_pt_en_burst", 128'(pt_en), 128'd1);
      end
      @(negedge clk);
      chk("t2_pt_en_end", 128'(pt_en), 128'd0);
      chk("t2_inflight", 128'(inflight), 128'd4);

      // credit limit
      credit_ret = 1'b1;
      repeat (4) @(negedge clk);
      credit_ret = 1'b0;
      chk("t3_inflight0", 128'(inflight), 128'd0);
      iss0 = issued;
      repeat (16) send();
      s_valid = 1'b1;
      s_data  = '1;
      repeat (3) @(negedge clk);
      chk("t3_stall", 128'(s_ready), 128'd0);
      s_valid = 1'b0;
      chk("t3_issued12", 128'(issued - iss0), 128'd12);
      chk("t3_inflight12", 128'(inflight), 128'd12);
      credit_ret = 1'b1;
      @(negedge clk);
      credit_ret = 1'b0;
      chk("t3_inflight11", 128'(inflight), 128'd11);
      chk("t3_no_same_cycle", 128'(pt_en), 128'd0);
      @(negedge clk);
      chk("t3_one_more", 128'(pt_en), 128'd1);
      chk("t3_inflight_back", 128'(inflight), 128'd12);
      repeat (3) @(negedge clk);
      chk("t3_issued13", 128'(issued - iss0), 128'd13);

      // credits returned while issuing leave the count unchanged
      credit_ret = 1'b1;
      repeat (12) @(negedge clk);
      credit_ret = 1'b0;
      repeat (2) @(negedge clk);
      chk("t4_inflight3", 128'(inflight), 128'd3);
      chk("t4_fifo_drained", 128'(q.size()), 128'd0);

      // rekey while blocks are in flight
      iss0 = issued;
      pulse_key(K2);
      chk("t4_drain_kr", 128'(key_ready), 128'd0);
      repeat (2) send();
      repeat (4) @(negedge clk);
      chk("t4_no_issue", 128'(issued - iss0), 128'd0);
      chk("t4_fsm_off", 128'(fsm_en), 128'd0);
      for (int i = 0; i < 3; i++) begin
         credit_ret = 1'b1;
         @(negedge clk);
         credit_ret = 1'b0;
         chk("t4_key_hold", key_out, K1);
      end
      fsm_cnt = 0;
      wait_ready();
      chk("t4_fsm_cycles", 128'(fsm_cnt), 128'd12);
      chk("t4_new_key", key_out, K2);
      repeat (4) @(negedge clk);
      chk("t4_inflight2", 128'(inflight), 128'd2);

      // reset mid-stream
      repeat (3) send();
      repeat (2) @(negedge clk);
      chk("t5_inflight5", 128'(inflight), 128'd5);
      pulse_key(K3);
      iss0 = issued;
      repeat (3) send();
      chk("t5_held", 128'(issued - iss0), 128'd0);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("t5_s_ready", 128'(s_ready), 128'd0);
      chk("t5_key_out", key_out, 128'd0);
      chk("t5_pt_out", pt_out, 128'd0);
      chk("t5_pt_en", 128'(pt_en), 128'd0);
      chk("t5_inflight", 128'(inflight), 128'd0);
      chk("t5_fsm_en", 128'(fsm_en), 128'd0);
      rst = 1'b0;
      iss0 = issued;
      repeat (6) @(negedge clk);
      chk("t5_no_issue", 128'(issued - iss0), 128'd0);
      chk("t5_empty", 128'(s_ready), 128'd1);
      chk("t5_idle_kr", 128'(key_ready), 128'd0);

      // stray credit with nothing in flight
`ifdef AES_FEED_ERR_EN
      chk("t6_err_clear", 128'(err), 128'd0);
`endif
      credit_ret = 1'b1;
      @(negedge clk);
      credit_ret = 1'b0;
      chk("t6_inflight_sat", 128'(inflight), 128'd0);
`ifdef AES_FEED_ERR_EN
      chk("t6_err_set", 128'(err), 128'd1);
      repeat (3) @(negedge clk);
      chk("t6_err_sticky", 128'(err), 128'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_err_rst", 128'(err), 128'd0);
`else
      repeat (3) @(negedge clk);
      chk("t6_inflight_hold", 128'(inflight), 128'd0);
`endif
      chk("sb_leftover", 128'(q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
